// File: rtl/rotary_quad_decoder.sv
// Quadrature rotary-encoder decoder: per-channel synchronizer and debounce filter
// feeding a detent-tracking FSM that emits one event and a position step per detent.
`timescale 1ns/1ps
module rotary_quad_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rotary_a,
  input  logic       rotary_b,
  output logic       rotary_event,
  output logic       rotary_left,
  output logic [7:0] position,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    REST   = 3'd0,
    CW1    = 3'd1,
    CW2    = 3'd2,
    CW3    = 3'd3,
    CCW1   = 3'd4,
    CCW2   = 3'd5,
    CCW3   = 3'd6,
    RESYNC = 3'd7
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  // Bit 1 is channel A, bit 0 is channel B, so filt_q is the FSM code {a,b}.
  logic [1:0]  sync1_q, sync2_q;
  logic [1:0]  filt_q, filt_d;
  logic [15:0] cnt_q [2];
  logic [15:0] cnt_d [2];

  state_t      state_q, state_d;
  logic        event_q, event_d;
  logic        left_q, left_d;
  logic [7:0]  pos_q, pos_d;
  logic [1:0]  code;

  assign code = filt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      filt_q  <= 2'b11;
      cnt_q[0] <= 16'd0;
      cnt_q[1] <= 16'd0;
    end else begin
      sync1_q <= {rotary_a, rotary_b};
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  // A channel must disagree with its filtered value for DEBOUNCE_CYCLES clocks in a row.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = 16'd0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          filt_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= REST;
      event_q <= 1'b0;
      left_q  <= 1'b0;
      pos_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      event_q <= event_d;
      left_q  <= left_d;
      pos_q   <= pos_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      REST: begin
        case (code)
          2'b01:   state_d = CW1;
          2'b10:   state_d = CCW1;
          2'b00:   state_d = RESYNC;
          default: state_d = REST;
        endcase
      end
      CW1: begin
        case (code)
          2'b00:   state_d = CW2;
          2'b11:   state_d = REST;
          2'b10:   state_d = RESYNC;
          default: state_d = CW1;
        endcase
      end
      CW2: begin
        case (code)
          2'b10:   state_d = CW3;
          2'b01:   state_d = CW1;
          2'b11:   state_d = RESYNC;
          default: state_d = CW2;
        endcase
      end
      CW3: begin
        case (code)
          2'b11:   state_d = REST;
          2'b00:   state_d = CW2;
          2'b01:   state_d = RESYNC;
          default: state_d = CW3;
        endcase
      end
      CCW1: begin
        case (code)
          2'b00:   state_d = CCW2;
          2'b11:   state_d = REST;
          2'b01:   state_d = RESYNC;
          default: state_d = CCW1;
        endcase
      end
      CCW2: begin
        case (code)
          2'b01:   state_d = CCW3;
          2'b10:   state_d = CCW1;
          2'b11:   state_d = RESYNC;
          default: state_d = CCW2;
        endcase
      end
      CCW3: begin
        case (code)
          2'b11:   state_d = REST;
          2'b00:   state_d = CCW2;
          2'b10:   state_d = RESYNC;
          default: state_d = CCW3;
        endcase
      end
      default: begin
        if (code == 2'b11) state_d = REST;
      end
    endcase
  end

  // Only leaving CW3/CCW3 for REST completes a detent; direction is held otherwise.
  always_comb begin
    event_d = 1'b0;
    left_d  = left_q;
    pos_d   = pos_q;
    if (code == 2'b11) begin
      if (state_q == CW3) begin
        event_d = 1'b1;
        left_d  = 1'b0;
        pos_d   = pos_q + 8'd1;
      end else if (state_q == CCW3) begin
        event_d = 1'b1;
        left_d  = 1'b1;
        pos_d   = pos_q - 8'd1;
      end
    end
  end

  assign rotary_event = event_q;
  assign rotary_left  = left_q;
  assign position     = pos_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_rotary_quad_decoder.sv
// Bench for rotary_quad_decoder: directed encoder sequences, with expected detent
// events queued at stimulus time and checked by an independent event monitor.
`timescale 1ns/1ps
module tb_rotary_quad_decoder;

  localparam int D    = 4;
  localparam int HOLD = 20;
  localparam int LAT  = 2 + D;

  localparam logic [2:0] S_REST = 3'd0;
  localparam logic [2:0] S_CW2  = 3'd2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rotary_a = 1'b1;
  logic       rotary_b = 1'b1;
  logic       rotary_event;
  logic       rotary_left;
  logic [7:0] position;
  logic [2:0] dbg_state;

  rotary_quad_decoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clock        (clock),
    .reset        (reset),
    .rotary_a     (rotary_a),
    .rotary_b     (rotary_b),
    .rotary_event (rotary_event),
    .rotary_left  (rotary_left),
    .position     (position),
    .dbg_state_o  (dbg_state)
  );

  // Clock and cycle count
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entry: {expected cycle[31:0], left, position[7:0]}
  logic [40:0] exp_q[$];
  logic [7:0]  exp_pos  = 8'h00;
  logic        exp_left = 1'b0;
  logic [7:0]  seen_mask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drivers
  task automatic drive(input logic [1:0] ab, input int hold, input int dir);
    @(negedge clock);
    rotary_a = ab[1];
    rotary_b = ab[0];
    if (dir != 0) begin
      exp_left = (dir == 2);
      exp_pos  = (dir == 2) ? exp_pos - 8'd1 : exp_pos + 8'd1;
      exp_q.push_back({32'(cyc + 1 + LAT), exp_left, exp_pos});
    end
    repeat (hold) begin
      @(posedge clock);
      #1;
      seen_mask[dbg_state] = 1'b1;
    end
  endtask

  task automatic cw_detent();
    drive(2'b01, HOLD, 0);
    drive(2'b00, HOLD, 0);
    drive(2'b10, HOLD, 0);
    drive(2'b11, HOLD, 1);
  endtask

  task automatic ccw_detent();
    drive(2'b10, HOLD, 0);
    drive(2'b00, HOLD, 0);
    drive(2'b01, HOLD, 0);
    drive(2'b11, HOLD, 2);
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    repeat (n) @(posedge clock);
    @(negedge clock);
    reset    = 1'b0;
    exp_pos  = 8'h00;
    exp_left = 1'b0;
  endtask

  // Monitor: every event pulse must match the head of the expected queue
  always @(negedge clock) begin
    logic [40:0] e;
    if (rotary_event === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("event_cycle", cyc, e[40:9]);
        check("event_left", {31'd0, rotary_left}, {31'd0, e[8]});
        check("event_position", {24'd0, position}, {24'd0, e[7:0]});
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_event", {31'd0, rotary_event}, 32'd0);
    check("reset_left", {31'd0, rotary_left}, 32'd0);
    check("reset_position", {24'd0, position}, 32'h00);
    check("reset_state", {29'd0, dbg_state}, {29'd0, S_REST});
    reset = 1'b0;

    // Clean CW detent
    seen_mask = 8'h00;
    cw_detent();
    check("cw_position", {24'd0, position}, 32'h01);
    check("cw_left", {31'd0, rotary_left}, 32'd0);
    check("cw_states", {24'd0, seen_mask}, 32'h0F);

    // Clean CCW detent from reset wraps to FF, then CW wraps back to 00
    do_reset(2);
    seen_mask = 8'h00;
    ccw_detent();
    check("ccw_position", {24'd0, position}, 32'hFF);
    check("ccw_left", {31'd0, rotary_left}, 32'd1);
    check("ccw_states", {24'd0, seen_mask}, 32'h71);
    cw_detent();
    check("wrap_up_position", {24'd0, position}, 32'h00);
    check("wrap_up_left", {31'd0, rotary_left}, 32'd0);

    // Short glitch on A is filtered out
    seen_mask = 8'h00;
    drive(2'b01, 3, 0);
    drive(2'b11, HOLD, 0);
    check("glitch3_states", {24'd0, seen_mask}, 32'h01);

    // Glitch of DEBOUNCE_CYCLES passes: CW1 entered, then back to REST
    seen_mask = 8'h00;
    drive(2'b01, 4, 0);
    drive(2'b11, HOLD, 0);
    check("glitch4_states", {24'd0, seen_mask}, 32'h03);
    check("glitch4_position", {24'd0, position}, 32'h00);

    // Reversal mid-path
    seen_mask = 8'h00;
    drive(2'b01, HOLD, 0);
    drive(2'b00, HOLD, 0);
    drive(2'b01, HOLD, 0);
    drive(2'b11, HOLD, 0);
    check("reversal_states", {24'd0, seen_mask}, 32'h07);
    check("reversal_state", {29'd0, dbg_state}, {29'd0, S_REST});
    check("reversal_position", {24'd0, position}, 32'h00);

    // Diagonal jump goes through RESYNC, then a clean CW detent still counts
    seen_mask = 8'h00;
    drive(2'b01, HOLD, 0);
    drive(2'b10, HOLD, 0);
    drive(2'b11, HOLD, 0);
    check("diagonal_states", {24'd0, seen_mask}, 32'h83);
    check("diagonal_state", {29'd0, dbg_state}, {29'd0, S_REST});
    cw_detent();
    check("after_resync_position", {24'd0, position}, 32'h01);

    // Reset while in CW2 abandons the detent
    drive(2'b01, HOLD, 0);
    drive(2'b00, HOLD, 0);
    check("pre_reset_state", {29'd0, dbg_state}, {29'd0, S_CW2});
    do_reset(2);
    drive(2'b10, HOLD, 0);
    drive(2'b11, HOLD, 0);
    check("midreset_position", {24'd0, position}, 32'h00);
    check("midreset_left", {31'd0, rotary_left}, 32'd0);
    check("midreset_state", {29'd0, dbg_state}, {29'd0, S_REST});

    // Two back-to-back CCW detents
    ccw_detent();
    ccw_detent();
    check("double_ccw_position", {24'd0, position}, 32'hFE);
    check("double_ccw_left", {31'd0, rotary_left}, 32'd1);

    repeat (10) @(negedge clock);
    check("pending_events", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rotary_quad_decoder.md
ROTARY_QUAD_DECODER -- requirements
Module: rotary_quad_decoder

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, consecutive clocks a synchronized input must differ from its filtered value before the filtered value updates; legal range 1..65535.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rotary_a  input  1  raw encoder channel A, asynchronous, rest level 1.
REQ-005 rotary_b  input  1  raw encoder channel B, asynchronous, rest level 1.
REQ-006 rotary_event  output  1  one-clock pulse per completed detent.
REQ-007 rotary_left  output  1  direction of most recent detent: 1 = left (CCW), 0 = right (CW); held between events.
REQ-008 position  output  8  signed-agnostic detent counter, modulo 256.

Function
REQ-009 Each channel SHALL pass a 2-flop synchronizer (sync1, sync2) before any other logic.
REQ-010 Per channel, a 16-bit counter SHALL count clocks where sync2 != filtered; it SHALL clear to 0 on any clock where sync2 == filtered.
REQ-011 When sync2 != filtered and counter == DEBOUNCE_CYCLES-1, filtered SHALL load sync2 and counter SHALL clear.
REQ-012 Latency: raw input stable from before edge k -> filtered updates at edge k+1+DEBOUNCE_CYCLES; pulses shorter than DEBOUNCE_CYCLES clocks at sync2 SHALL be ignored.
REQ-013 FSM input code = {filtered_a, filtered_b}; states REST, CW1, CW2, CW3, CCW1, CCW2, CCW3, RESYNC.
REQ-014 CW path codes: REST=11 -> CW1=01 -> CW2=00 -> CW3=10 -> REST=11; CCW path: REST=11 -> CCW1=10 -> CCW2=00 -> CCW3=01 -> REST=11.
REQ-015 In any path state: code equal to current state's code -> stay; next code in path -> advance; previous code in path -> step back one state (CW1/CCW1 step back to REST with no event).
REQ-016 In any state, the remaining (two-bit-change) code SHALL go to RESYNC; from REST, code 00 SHALL go to RESYNC.
REQ-017 RESYNC SHALL hold until code == 11, then go to REST with no event.
REQ-018 Transition CW3 -> REST SHALL, on the same edge, set rotary_event=1, rotary_left=0, position=position+1.
REQ-019 Transition CCW3 -> REST SHALL, on the same edge, set rotary_event=1, rotary_left=1, position=position-1.
REQ-020 rotary_event SHALL be 0 on every other clock; no two events on consecutive clocks are possible.
REQ-021 position SHALL wrap 255+1 -> 0 and 0-1 -> 255.
REQ-022 A completed detent's event appears at edge k+2+DEBOUNCE_CYCLES where edge k is the first sample of the final raw transition to 11.
REQ-023 Both channels changing in the same cycle at the filtered stage SHALL be treated per REQ-016 (never an event).

Reset
REQ-024 On reset: sync1, sync2, filtered = 1 for both channels; debounce counters = 0; FSM = REST.
REQ-025 On reset: rotary_event = 0, rotary_left = 0, position = 8'h00.
REQ-026 Reset asserted mid-sequence SHALL abandon the sequence; no event is produced for it after reset deasserts, even if the remaining codes follow.
REQ-027 Reset SHALL take priority over any concurrent event or counter update.

Verification (DEBOUNCE_CYCLES = 4, each code held 20 clocks)
REQ-028 Reset, then a,b = 11->01->00->10->11 -> exactly one rotary_event pulse, rotary_left=0, position=1; pulse occurs 6 clocks after raw change to 11.
REQ-029 From reset, a,b = 11->10->00->01->11 -> one pulse, rotary_left=1, position=8'hFF (wrap).
REQ-030 From REST, rotary_a glitches to 0 for 3 clocks -> filtered_a never changes, no event; glitch of 4 clocks -> CW1 entered (no event).
REQ-031 Sequence 11->01->00->01->11 (reversal) -> no event, FSM ends in REST, position unchanged.
REQ-032 Sequence 11->01->10->11 (diagonal jump) -> RESYNC then REST, no event; a following clean CW detent -> exactly one event, position+1.
REQ-033 Reset pulsed while in CW2, inputs continue 10->11 -> no event; position=0, rotary_left=0.
